io_channel_bank: RTL and testbench
==================================

IO_CHANNEL_BANK -- requirements
Module: io_channel_bank

Interface
REQ-001 The block SHALL have parameter NUM_CHANNELS, default 32, meaning the number of IO channel registers (legal 2..128).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 15, meaning the channel word width (legal 1..21).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8, meaning the number of TX frame FIFO entries (power of two, at least 2).
REQ-004 The block SHALL have parameter OUT_MASK, default all ones, NUM_CHANNELS bits wide; bit i set means writes to channel i are mirrored to UART.
REQ-005 The block SHALL have SW = $clog2(NUM_CHANNELS) as the select width.
REQ-006 The block SHALL have port clock, input, 1 bit: the single clock, rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port IO_read_sel, input, SW bits: read channel select.
REQ-009 The block SHALL have port IO_read_data, output, DATA_WIDTH bits: the selected channel value.
REQ-010 The block SHALL have port IO_write_en, input, 1 bit: core write strobe.
REQ-011 The block SHALL have port IO_write_sel, input, SW bits: write channel select.
REQ-012 The block SHALL have port IO_write_data, input, DATA_WIDTH bits: core write data.
REQ-013 The block SHALL have port tx_byte, output, 8 bits: the byte offered to the external uart_tx.
REQ-014 The block SHALL have port tx_valid and port tx_ready: tx_valid is an output, tx_ready is an input, each 1 bit; together they form the valid/ready handshake to uart_tx.
REQ-015 The block SHALL have port rx_byte, input, 8 bits, and port rx_valid, input, 1 bit: a byte from uart_rx, valid for one cycle.
REQ-016 The block SHALL have port ovf_count, output, 8 bits: the count of dropped TX frames, saturating.

Function
REQ-017 IO_read_data SHALL be combinational: chan[IO_read_sel]; a select of NUM_CHANNELS or more SHALL read 0.
REQ-018 A write with IO_write_en=1 and a select below NUM_CHANNELS SHALL update chan[sel] at the clock edge; the new value is readable the next cycle.
REQ-019 A write with a select of NUM_CHANNELS or more SHALL be ignored, with no FIFO push.
REQ-020 A core write to a channel with its OUT_MASK bit set SHALL push frame {sel, data} into the TX FIFO in the same edge, if the FIFO is not full.
REQ-021 If the FIFO is full, the register SHALL still update, the frame SHALL be dropped, and ovf_count SHALL increment, saturating at 255.
REQ-022 A simultaneous push and pop on a full FIFO SHALL be treated as full: the frame is dropped.
REQ-023 The frame encoding SHALL be 4 bytes, with the data zero-extended to 21 bits as d: B0 = {1, sel[6:0]}, B1 = {0, d[20:14]}, B2 = {0, d[13:7]}, B3 = {0, d[6:0]}.
REQ-024 The TX serializer FSM SHALL have states IDLE, B0, B1, B2 and B3.
REQ-025 In IDLE with the FIFO non-empty, the serializer SHALL pop the head into a holding register and enter B0 on the next cycle.
REQ-026 In each Bn state, tx_valid SHALL be 1 and tx_byte SHALL be byte n.
REQ-027 In Bn, the serializer SHALL advance on tx_valid&&tx_ready; B3 SHALL return to IDLE on acceptance.
REQ-028 tx_byte SHALL be held stable while tx_valid=1 and tx_ready=0.
REQ-029 The minimum frame spacing SHALL be 5 cycles: 1 IDLE cycle plus 4 bytes.
REQ-030 The RX deframer SHALL have states HUNT, P1, P2 and P3.
REQ-031 Any rx_valid byte with bit7=1, in any state, SHALL latch sel=bit[6:0] and enter P1.
REQ-032 In HUNT, a byte with bit7=0 SHALL be discarded.
REQ-033 In P1, P2 and P3, a byte with bit7=0 SHALL latch 7 payload bits and advance; P3 SHALL return to HUNT.
REQ-034 On P3 completion, the deframer SHALL write the low DATA_WIDTH bits of the payload into chan[sel] in that edge if sel is below NUM_CHANNELS; otherwise the frame SHALL be discarded.
REQ-035 An RX write SHALL never push to the TX FIFO.
REQ-036 If a core write and an RX write target the same channel in the same cycle, the core write SHALL win; the RX value SHALL be lost.
REQ-037 If a core write and an RX write target different channels in the same cycle, both SHALL take effect.
REQ-038 The FIFO pointers SHALL wrap modulo FIFO_DEPTH; the FIFO SHALL use an extra pointer bit to distinguish full from empty.

Reset
REQ-039 While reset=1 at an edge, all channel registers SHALL clear to 0, the FIFO SHALL empty, the TX FSM SHALL go to IDLE, the RX FSM SHALL go to HUNT, and ovf_count SHALL clear to 0.
REQ-040 After reset, tx_valid SHALL be 0 and IO_read_data SHALL be 0.
REQ-041 A reset asserted during a frame in flight SHALL abort it: the remaining bytes are never sent and the partial RX frame is discarded.
REQ-042 Core writes in the same cycle as reset SHALL be ignored.

Verification
REQ-043 The bench SHALL cover: write ch5=0x1234 with tx_ready=1 -> tx bytes 0x85,0x00,0x24,0x34; IO_read_sel=5 next cycle reads 0x1234.
REQ-044 The bench SHALL cover: tx_ready=0, 10 writes to ch1 with default depth -> 8 queued, ovf_count=2, ch1 holds the last value; releasing tx_ready emits 8 frames (32 bytes) in order.
REQ-045 The bench SHALL cover: RX bytes 0x83,0x00,0x7F,0x7F -> chan[3]=0x3FFF; RX bytes 0x83,0x01,0x81,0x00,0x00,0x05 -> the first frame is aborted and chan[1]=0x0005.
REQ-046 The bench SHALL cover: a core write ch2=0x0111 in the same cycle as an RX completion to ch2=0x0222 -> ch2=0x0111, and exactly one TX frame is emitted.
REQ-047 The bench SHALL cover: with OUT_MASK bit 4 clear, a write to ch4 -> no tx_valid, and the register still updates.
REQ-048 The bench SHALL cover: reset asserted after B1 is accepted -> tx_valid=0 the next cycle, FIFO empty, all channels 0, and ovf_count=0.

Source files
------------

// File: rtl/io_channel_bank.sv
// Bank of IO channel registers mirrored over a UART link: masked core writes are sent as
// 4-byte frames on TX, and frames arriving on RX write back into the bank.
module io_channel_bank #(
    parameter int NUM_CHANNELS = 32,
    parameter int DATA_WIDTH   = 15,
    parameter int FIFO_DEPTH   = 8,
    parameter logic [NUM_CHANNELS-1:0] OUT_MASK = {NUM_CHANNELS{1'b1}},
    parameter int SW           = $clog2(NUM_CHANNELS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [SW-1:0]         IO_read_sel,
    output logic [DATA_WIDTH-1:0] IO_read_data,
    input  logic                  IO_write_en,
    input  logic [SW-1:0]         IO_write_sel,
    input  logic [DATA_WIDTH-1:0] IO_write_data,
    output logic [7:0]            tx_byte,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_valid,
    output logic [7:0]            ovf_count
);
    localparam int FW = SW + DATA_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {TX_IDLE, TX_B0, TX_B1, TX_B2, TX_B3} tx_state_e;
    typedef enum logic [1:0] {RX_HUNT, RX_P1, RX_P2, RX_P3} rx_state_e;

    logic [DATA_WIDTH-1:0] chan_q [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0] chan_d [NUM_CHANNELS];
    logic [FW-1:0]         fifo_mem [FIFO_DEPTH];
    logic [PW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]         hold_q, hold_d;
    tx_state_e             tx_state_q, tx_state_d;
    rx_state_e             rx_state_q, rx_state_d;
    logic [6:0]            rx_sel_q, rx_sel_d;
    logic [13:0]           rx_pay_q, rx_pay_d;
    logic [7:0]            ovf_q, ovf_d;

    logic                  core_wr, push, drop, pop, fifo_full, fifo_empty, rx_wr;
    logic [DATA_WIDTH-1:0] rx_word;
    logic [6:0]            tx_sel7;
    logic [20:0]           tx_d21;

    assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
    assign fifo_full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign core_wr      = IO_write_en && (32'(IO_write_sel) < NUM_CHANNELS);
    assign push         = core_wr && OUT_MASK[IO_write_sel] && !fifo_full;
    assign drop         = core_wr && OUT_MASK[IO_write_sel] && fifo_full;
    assign pop          = (tx_state_q == TX_IDLE) && !fifo_empty;
    assign IO_read_data = (32'(IO_read_sel) < NUM_CHANNELS) ? chan_q[IO_read_sel] : '0;
    assign ovf_count    = ovf_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_sel_d   = rx_sel_q;
        rx_pay_d   = rx_pay_q;
        rx_wr      = 1'b0;
        rx_word    = DATA_WIDTH'({rx_pay_q, rx_byte[6:0]});
        if (rx_valid) begin
            if (rx_byte[7]) begin
                rx_sel_d   = rx_byte[6:0];
                rx_state_d = RX_P1;
            end else begin
                case (rx_state_q)
                    RX_P1: begin
                        rx_pay_d[13:7] = rx_byte[6:0];
                        rx_state_d     = RX_P2;
                    end
                    RX_P2: begin
                        rx_pay_d[6:0] = rx_byte[6:0];
                        rx_state_d    = RX_P3;
                    end
                    RX_P3: begin
                        rx_wr      = (32'(rx_sel_q) < NUM_CHANNELS);
                        rx_state_d = RX_HUNT;
                    end
                    default: rx_state_d = RX_HUNT;
                endcase
            end
        end
    end

    // Core write is applied last so it overrides an RX write to the same channel.
    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            chan_d[i] = chan_q[i];
        end
        if (rx_wr) begin
            chan_d[rx_sel_q[SW-1:0]] = rx_word;
        end
        if (core_wr) begin
            chan_d[IO_write_sel] = IO_write_data;
        end
        wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, pop};
        ovf_d    = (drop && ovf_q != 8'hFF) ? ovf_q + 8'd1 : ovf_q;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        hold_d     = hold_q;
        tx_sel7    = 7'(hold_q[FW-1:DATA_WIDTH]);
        tx_d21     = 21'(hold_q[DATA_WIDTH-1:0]);
        tx_valid   = (tx_state_q != TX_IDLE);
        tx_byte    = 8'h00;
        case (tx_state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    hold_d     = fifo_mem[rd_ptr_q[PW-1:0]];
                    tx_state_d = TX_B0;
                end
            end
            TX_B0: begin
                tx_byte = {1'b1, tx_sel7};
                if (tx_ready) tx_state_d = TX_B1;
            end
            TX_B1: begin
                tx_byte = {1'b0, tx_d21[20:14]};
                if (tx_ready) tx_state_d = TX_B2;
            end
            TX_B2: begin
                tx_byte = {1'b0, tx_d21[13:7]};
                if (tx_ready) tx_state_d = TX_B3;
            end
            TX_B3: begin
                tx_byte = {1'b0, tx_d21[6:0]};
                if (tx_ready) tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PW-1:0]] <= {IO_write_sel, IO_write_data};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                chan_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            hold_q     <= '0;
            tx_state_q <= TX_IDLE;
            rx_state_q <= RX_HUNT;
            rx_sel_q   <= '0;
            rx_pay_q   <= '0;
            ovf_q      <= '0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                chan_q[i] <= chan_d[i];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            hold_q     <= hold_d;
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
            rx_sel_q   <= rx_sel_d;
            rx_pay_q   <= rx_pay_d;
            ovf_q      <= ovf_d;
        end
    end
endmodule

// File: tb/tb_io_channel_bank.sv
// Self-checking bench for io_channel_bank: a queue-based reference model is compared with the
// DUT on every cycle, and directed scenarios pin the model with hand-computed values.
module tb_io_channel_bank;
    localparam int N  = 24;
    localparam int DW = 15;
    localparam int FD = 8;
    localparam logic [N-1:0] MASK = 24'hFFFFEF;

    logic          clock = 1'b0;
    logic          reset;
    logic [4:0]    IO_read_sel;
    logic [DW-1:0] IO_read_data;
    logic          IO_write_en;
    logic [4:0]    IO_write_sel;
    logic [DW-1:0] IO_write_data;
    logic [7:0]    tx_byte;
    logic          tx_valid;
    logic          tx_ready;
    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic [7:0]    ovf_count;

    int chan_m [N];
    int fifo_m [$];
    int model_log [$];
    int dut_log [$];
    int cur_m, left_m, ovf_m;
    int rx_need, rx_sel_m, rx_acc, rx_val, ws;
    bit rx_hit, full_pre;
    bit model_live = 1'b0;
    int checks = 0;
    int errors = 0;

    io_channel_bank #(
        .NUM_CHANNELS(N), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .OUT_MASK(MASK)
    ) dut (
        .clock(clock), .reset(reset),
        .IO_read_sel(IO_read_sel), .IO_read_data(IO_read_data),
        .IO_write_en(IO_write_en), .IO_write_sel(IO_write_sel), .IO_write_data(IO_write_data),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .ovf_count(ovf_count)
    );

    always #5 clock = ~clock;

    function automatic int frame_byte(input int f, input int n);
        int s = f >> 21;
        int d = f & 'h1FFFFF;
        case (n)
            0:       return 'h80 | s;
            1:       return (d >> 14) & 'h7F;
            2:       return (d >> 7) & 'h7F;
            default: return d & 'h7F;
        endcase
    endfunction

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: frames live in a queue, the serializer is a count of bytes left.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N; i++) chan_m[i] = 0;
            fifo_m.delete();
            left_m     = 0;
            ovf_m      = 0;
            rx_need    = 0;
            model_live = 1'b1;
        end else if (model_live) begin
            full_pre = (fifo_m.size() == FD);
            if (left_m == 0) begin
                if (fifo_m.size() > 0) begin
                    cur_m  = fifo_m.pop_front();
                    left_m = 4;
                end
            end else if (tx_ready) begin
                model_log.push_back(frame_byte(cur_m, 4 - left_m));
                left_m--;
            end
            rx_hit = 1'b0;
            if (rx_valid) begin
                if (rx_byte[7]) begin
                    rx_sel_m = int'(rx_byte[6:0]);
                    rx_need  = 3;
                    rx_acc   = 0;
                end else if (rx_need > 0) begin
                    rx_acc = rx_acc * 128 + int'(rx_byte[6:0]);
                    rx_need--;
                    if (rx_need == 0 && rx_sel_m < N) begin
                        rx_hit = 1'b1;
                        rx_val = rx_acc & ((1 << DW) - 1);
                    end
                end
            end
            if (rx_hit) chan_m[rx_sel_m] = rx_val;
            ws = int'(IO_write_sel);
            if (IO_write_en && ws < N) begin
                chan_m[ws] = int'(IO_write_data);
                if (MASK[ws]) begin
                    if (full_pre) ovf_m = (ovf_m < 255) ? ovf_m + 1 : 255;
                    else fifo_m.push_back((ws << 21) | int'(IO_write_data));
                end
            end
        end
    end

    always @(negedge clock) begin
        if (model_live) begin
            check_output("tx_valid", int'(tx_valid), (left_m > 0) ? 1 : 0);
            if (left_m > 0) check_output("tx_byte", int'(tx_byte), frame_byte(cur_m, 4 - left_m));
            check_output("ovf_count", int'(ovf_count), ovf_m);
            check_output("read_data", int'(IO_read_data),
                         (int'(IO_read_sel) < N) ? chan_m[int'(IO_read_sel)] : 0);
            if (tx_valid && tx_ready && !reset) dut_log.push_back(int'(tx_byte));
        end
    end

    task automatic apply_stimulus(input logic we, input int sel, input int data,
                                  input logic rv, input int rb);
        IO_write_en   = we;
        IO_write_sel  = 5'(sel);
        IO_write_data = DW'(data);
        rx_valid      = rv;
        rx_byte       = 8'(rb);
        @(posedge clock);
        #1;
        IO_write_en = 1'b0;
        rx_valid    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic read_check(input int sel, input int exp, input string name);
        IO_read_sel = 5'(sel);
        #2;
        check_output(name, int'(IO_read_data), exp);
        @(posedge clock);
        #1;
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int k = 0;
        while (dut_log.size() < n && k < budget) begin
            @(posedge clock);
            #1;
            k++;
        end
        check_output(name, dut_log.size(), n);
    endtask

    task automatic check_frame(input int base, input int b0, input int b1, input int b2,
                               input int b3, input string name);
        int exp [4];
        exp = '{b0, b1, b2, b3};
        for (int i = 0; i < 4; i++) begin
            check_output(name, (base + i < dut_log.size()) ? dut_log[base + i] : -1, exp[i]);
        end
    endtask

    initial begin
        int base;
        int k;
        reset = 1'b1; IO_read_sel = '0; IO_write_en = 1'b0; IO_write_sel = '0;
        IO_write_data = '0; tx_ready = 1'b0; rx_valid = 1'b0; rx_byte = '0;
        #1;
        apply_stimulus(1'b1, 7, 'h0777, 1'b0, 0);
        apply_stimulus(1'b1, 7, 'h0777, 1'b0, 0);
        reset = 1'b0;
        check_output("reset_tx_valid", int'(tx_valid), 0);
        check_output("reset_ovf", int'(ovf_count), 0);
        read_check(7, 0, "reset_ch7");
        read_check(0, 0, "reset_ch0");

        tx_ready = 1'b1;
        base = dut_log.size();
        apply_stimulus(1'b1, 5, 'h1234, 1'b0, 0);
        read_check(5, 'h1234, "ch5_readback");
        wait_log(base + 4, 30, "ch5_frame_len");
        check_frame(base, 'h85, 'h00, 'h24, 'h34, "ch5_frame");

        idle(10);
        base = dut_log.size();
        apply_stimulus(1'b1, 4, 'h0ABC, 1'b0, 0);
        apply_stimulus(1'b1, 27, 'h1FFF, 1'b0, 0);
        idle(10);
        check_output("masked_no_frame", dut_log.size(), base);
        read_check(4, 'h0ABC, "ch4_value");
        read_check(27, 0, "out_of_range_read");

        tx_ready = 1'b0;
        idle(2);
        base = dut_log.size();
        // The ch0 frame sits in the serializer, so the ch1 burst sees all FIFO slots free.
        apply_stimulus(1'b1, 0, 'h0055, 1'b0, 0);
        idle(2);
        for (int i = 1; i <= 10; i++) apply_stimulus(1'b1, 1, i * 'h111, 1'b0, 0);
        check_output("ovf_after_burst", int'(ovf_count), 2);
        read_check(1, 'h0AAA, "ch1_last_value");
        tx_ready = 1'b1;
        wait_log(base + 36, 400, "burst_len");
        check_frame(base, 'h80, 'h00, 'h00, 'h55, "burst_frame_ch0");
        check_frame(base + 4, 'h81, 'h00, 'h02, 'h11, "burst_frame_first");
        check_frame(base + 32, 'h81, 'h00, 'h11, 'h08, "burst_frame_last");

        idle(5);
        base = dut_log.size();
        apply_stimulus(1'b0, 0, 0, 1'b1, 'h83);
        apply_stimulus(1'b0, 0, 0, 1'b1, 'h00);
        apply_stimulus(1'b0, 0, 0, 1'b1, 'h7F);
        apply_stimulus(1'b0, 0, 0, 1'b1, 'h7F);
        read_check(3, 'h3FFF, "rx_ch3");
        apply_stimulus(1'b0, 0, 0, 1'b1, 'h83);
        apply_stimulus(1'b0, 0, 0, 1'b1, 'h01);
        apply_stimulus(1'b0, 0, 0, 1'b1, 'h81);
        apply_stimulus(1'b0, 0, 0, 1'b1, 'h00);
        apply_stimulus(1'b0, 0, 0, 1'b1, 'h00);
        apply_stimulus(1'b0, 0, 0, 1'b1, 'h05);
        read_check(1, 'h0005, "rx_ch1_after_abort");
        read_check(3, 'h3FFF, "rx_ch3_kept");
        idle(8);
        check_output("rx_no_tx", dut_log.size(), base);

        apply_stimulus(1'b0, 0, 0, 1'b1, 'h82);
        apply_stimulus(1'b0, 0, 0, 1'b1, 'h00);
        apply_stimulus(1'b0, 0, 0, 1'b1, 'h04);
        apply_stimulus(1'b1, 2, 'h0111, 1'b1, 'h22);
        read_check(2, 'h0111, "ch2_core_wins");
        wait_log(base + 4, 30, "ch2_frame_len");
        idle(10);
        check_output("ch2_one_frame", dut_log.size(), base + 4);
        check_frame(base, 'h82, 'h00, 'h02, 'h11, "ch2_frame");

        apply_stimulus(1'b0, 0, 0, 1'b1, 'h83);
        apply_stimulus(1'b0, 0, 0, 1'b1, 'h00);
        apply_stimulus(1'b0, 0, 0, 1'b1, 'h00);
        apply_stimulus(1'b1, 6, 'h0006, 1'b1, 'h01);
        read_check(3, 'h0001, "dual_write_rx");
        read_check(6, 'h0006, "dual_write_core");
        idle(15);

        base = dut_log.size();
        check_output("pre_reset_ovf", int'(ovf_count), 2);
        apply_stimulus(1'b1, 6, 'h1555, 1'b1, 'h85);
        apply_stimulus(1'b1, 7, 'h0777, 1'b1, 'h00);
        apply_stimulus(1'b1, 8, 'h0888, 1'b0, 0);
        k = 0;
        while (dut_log.size() < base + 2 && k < 20) begin
            @(posedge clock);
            #1;
            k++;
        end
        check_output("pre_reset_bytes", dut_log.size(), base + 2);
        tx_ready = 1'b0;
        reset    = 1'b1;
        apply_stimulus(1'b1, 9, 'h0999, 1'b0, 0);
        reset = 1'b0;
        check_output("post_reset_tx_valid", int'(tx_valid), 0);
        check_output("post_reset_ovf", int'(ovf_count), 0);
        for (int c = 0; c < N; c++) read_check(c, 0, "post_reset_chan");
        tx_ready = 1'b1;
        apply_stimulus(1'b0, 0, 0, 1'b1, 'h00);
        apply_stimulus(1'b0, 0, 0, 1'b1, 'h07);
        idle(15);
        check_output("post_reset_no_tx", dut_log.size(), base + 2);
        read_check(5, 0, "post_reset_rx_discard");

        tx_ready = 1'b0;
        for (int i = 0; i < 300; i++) apply_stimulus(1'b1, 10, i, 1'b0, 0);
        check_output("ovf_saturated", int'(ovf_count), 255);
        reset = 1'b1;
        apply_stimulus(1'b0, 0, 0, 1'b0, 0);
        reset = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            int ph = cyc / 500;
            IO_read_sel = 5'($urandom_range(0, 31));
            tx_ready    = ($urandom_range(0, 9) < 3 + 2 * (ph % 4));
            reset       = ($urandom_range(0, 399) == 0);
            apply_stimulus($urandom_range(0, 2) == 0, $urandom_range(0, 31),
                           int'($urandom_range(0, 32767)), $urandom_range(0, 1) == 1,
                           ($urandom_range(0, 3) == 0) ? ('h80 | $urandom_range(0, 35))
                                                       : $urandom_range(0, 127));
            reset = 1'b0;
        end

        tx_ready = 1'b1;
        idle(80);
        check_output("log_len", dut_log.size(), model_log.size());
        for (int i = 0; i < dut_log.size() && i < model_log.size(); i++) begin
            check_output("log_byte", dut_log[i], model_log[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not reach the end");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
